snn_config_loader: RTL

Byte-serial configuration loader sitting directly upstream of the SNN-with-delays top level. It accepts a stream of 8-bit configuration bytes and assembles the flat weight, delay, threshold, decay and refractory-period vectors that the network consumes. It asserts config_done once a complete image has been loaded, and the network enable is gated by that signal.

---
 rtl/snn_cfg_pkg.sv | 21 ++
 rtl/snn_config_loader_if.sv | 10 +
 rtl/snn_cfg_byte_reg.sv | 18 +
 rtl/snn_config_loader.sv | 83 ++++++++
 4 files changed

// File: rtl/snn_cfg_pkg.sv
// rtl/snn_cfg_pkg.sv - shared sizes, address map and FSM encoding for the SNN config loader
package snn_cfg_pkg;

  localparam int WEIGHT_BYTES = 144;
  localparam int DELAY_BYTES  = 64;
  localparam int PARAM_BYTES  = 3;
  localparam int TOTAL_BYTES  = WEIGHT_BYTES + DELAY_BYTES + PARAM_BYTES;

  localparam int WEIGHT_BASE = 0;
  localparam int DELAY_BASE  = WEIGHT_BASE + WEIGHT_BYTES;
  localparam int THRESH_ADDR = DELAY_BASE + DELAY_BYTES;
  localparam int DECAY_ADDR  = THRESH_ADDR + 1;
  localparam int REFRAC_ADDR = THRESH_ADDR + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/snn_config_loader_if.sv
// rtl/snn_config_loader_if.sv - byte-stream load handshake between host and config loader
interface snn_config_loader_if;
  logic       load_start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output load_start, output data_in, output data_valid, input data_ready);
  modport slave  (input load_start, input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/snn_cfg_byte_reg.sv
// rtl/snn_cfg_byte_reg.sv - one 8-bit configuration byte with sync reset and write enable
module snn_cfg_byte_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 8'h00;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/snn_config_loader.sv
// rtl/snn_config_loader.sv - assembles the SNN weight/delay/parameter image from a byte stream
module snn_config_loader
  import snn_cfg_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  snn_config_loader_if.slave        cfg,
  output logic [WEIGHT_BYTES*8-1:0] weights,
  output logic [DELAY_BYTES*8-1:0]  delays,
  output logic [7:0]                threshold,
  output logic [7:0]                decay,
  output logic [7:0]                refractory_period,
  output logic [7:0]                byte_count,
  output logic                      config_done,
  output logic                      load_error
);

  state_t state;
  state_t state_next;
  logic   accept;
  logic   last_byte;
  logic [TOTAL_BYTES*8-1:0] image;

  assign cfg.data_ready = (state == ST_LOAD);
  // A restart pulse takes priority over a coincident byte, so that byte is dropped.
  assign accept    = cfg.data_valid && cfg.data_ready && !cfg.load_start;
  assign last_byte = (byte_count == 8'(TOTAL_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (cfg.load_start) begin
      state_next = ST_LOAD;
    end else if (accept && last_byte) begin
      state_next = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_count  <= 8'd0;
      config_done <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      if (cfg.data_valid && (state != ST_LOAD)) begin
        load_error <= 1'b1;
      end
      if (cfg.load_start) begin
        byte_count  <= 8'd0;
        config_done <= 1'b0;
      end else if (accept) begin
        byte_count <= byte_count + 8'd1;
        if (last_byte) begin
          config_done <= 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < TOTAL_BYTES; i++) begin : g_bytes
    snn_cfg_byte_reg u_byte (
      .clk   (clk),
      .reset (reset),
      .we    (accept && (byte_count == 8'(i))),
      .d     (cfg.data_in),
      .q     (image[8*i +: 8])
    );
  end

  assign weights           = image[WEIGHT_BASE*8 +: WEIGHT_BYTES*8];
  assign delays            = image[DELAY_BASE*8 +: DELAY_BYTES*8];
  assign threshold         = image[THRESH_ADDR*8 +: 8];
  assign decay             = image[DECAY_ADDR*8 +: 8];
  assign refractory_period = image[REFRAC_ADDR*8 +: 8];

endmodule
